// File: rtl/spike_latency_encoder_pkg.sv
// Shared definitions for the latency encoder: default geometry and FSM state encoding.
package spike_latency_encoder_pkg;

    localparam int P_WIDTH_DEF = 8;   // pixel bit width, window = 2**P_WIDTH_DEF ticks
    localparam int P_S_DEF     = 42;  // synapses / pixels per frame
    localparam int P_N_DEF     = 8;   // classifier neurons
    localparam int P_GAP_DEF   = 4;   // idle cycles after each emit cycle

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_EMIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/spike_latency_encoder_match.sv
// Per-pixel fire decision: a pixel fires on the tick equal to its latency,
// unless its intensity is zero (zero never fires).
module spike_latency_encoder_match
    import spike_latency_encoder_pkg::*;
#(
    parameter int p_width = P_WIDTH_DEF
) (
    input  logic [p_width-1:0] i_lat,
    input  logic [p_width-1:0] i_pix,
    input  logic [p_width-1:0] i_tick,
    output logic               o_hit
);

    // Latency compare masked by nonzero intensity.
    always_comb begin
        o_hit = 1'b0;
        if ((i_lat == i_tick) && (i_pix != {p_width{1'b0}})) begin
            o_hit = 1'b1;
        end else begin
            o_hit = 1'b0;
        end
    end

endmodule

// File: rtl/spike_latency_encoder.sv
// Time-to-first-spike encoder: accepts a frame of pixels, emits one synapse event per
// nonzero pixel at a tick inversely related to its brightness, and stops early on the
// classifier's winner spike, latching it as the frame result.
module spike_latency_encoder
    import spike_latency_encoder_pkg::*;
#(
    parameter int p_width = P_WIDTH_DEF,
    parameter int p_s     = P_S_DEF,
    parameter int p_n     = P_N_DEF,
    parameter int p_gap   = P_GAP_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_frame_valid,
    output logic                   o_frame_ready,
    input  logic [p_s*p_width-1:0] i_pixels,
    input  logic [p_n:1]           i_spike,
    output logic [p_s:1]           o_event,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [p_n:1]           o_winner,
    output logic                   o_timeout
);

    localparam int                 GAP_W    = $clog2(p_gap + 1);
    localparam logic [p_width-1:0] TICK_MAX = {p_width{1'b1}};
    localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(p_gap - 1);

    state_t             state_q;
    logic [p_width-1:0] tick_q;
    logic [p_width-1:0] tick_d;
    logic [GAP_W-1:0]   gap_q;
    logic [p_width-1:0] pix_q [1:p_s];
    logic [p_width-1:0] lat_q [1:p_s];
    logic [p_width-1:0] lat_d [1:p_s];
    logic [p_s:1]       hit_s;
    logic [p_s:1]       event_q;
    logic               busy_q;
    logic               done_q;
    logic [p_n:1]       winner_q;
    logic               timeout_q;
    logic               spike_s;

    assign spike_s       = (i_spike != {p_n{1'b0}});
    assign o_frame_ready = (state_q == ST_IDLE) & ~i_rst;
    assign o_event       = event_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_winner      = winner_q;
    assign o_timeout     = timeout_q;

    // Tick of the upcoming emit cycle: 0 when leaving LOAD, otherwise one past the current tick.
    always_comb begin
        tick_d = tick_q;
        if (state_q == ST_LOAD) begin
            tick_d = {p_width{1'b0}};
        end else begin
            tick_d = tick_q + {{(p_width-1){1'b0}}, 1'b1};
        end
    end

    // Latencies are formed in LOAD; used directly so the first emit can be registered on time.
    always_comb begin
        for (int k = 1; k <= p_s; k++) begin
            lat_d[k] = lat_q[k];
            if (state_q == ST_LOAD) begin
                lat_d[k] = TICK_MAX - pix_q[k];
            end else begin
                lat_d[k] = lat_q[k];
            end
        end
    end

    for (genvar k = 1; k <= p_s; k++) begin : g_match
        spike_latency_encoder_match #(
            .p_width (p_width)
        ) u_match (
            .i_lat  (lat_d[k]),
            .i_pix  (pix_q[k]),
            .i_tick (tick_d),
            .o_hit  (hit_s[k])
        );
    end

    // Frame sequencer: state, counters, pixel/latency registers and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            tick_q    <= {p_width{1'b0}};
            gap_q     <= {GAP_W{1'b0}};
            event_q   <= {p_s{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            winner_q  <= {p_n{1'b0}};
            timeout_q <= 1'b0;
            for (int k = 1; k <= p_s; k++) begin
                pix_q[k] <= {p_width{1'b0}};
                lat_q[k] <= {p_width{1'b0}};
            end
        end else begin
            done_q  <= 1'b0;
            event_q <= {p_s{1'b0}};
            for (int k = 1; k <= p_s; k++) begin
                lat_q[k] <= lat_d[k];
            end
            case (state_q)
                ST_IDLE: begin
                    if (i_frame_valid) begin
                        for (int k = 1; k <= p_s; k++) begin
                            pix_q[k] <= i_pixels[k*p_width-1 -: p_width];
                        end
                        winner_q  <= {p_n{1'b0}};
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tick_q  <= tick_d;
                    event_q <= hit_s;
                    state_q <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (spike_s) begin
                        winner_q  <= i_spike;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        gap_q   <= {GAP_W{1'b0}};
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (spike_s) begin
                        // Winner takes priority over a coincident timeout.
                        winner_q  <= i_spike;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end else if (gap_q == GAP_LAST) begin
                        if (tick_q == TICK_MAX) begin
                            winner_q  <= {p_n{1'b0}};
                            timeout_q <= 1'b1;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end else begin
                            tick_q  <= tick_d;
                            event_q <= hit_s;
                            state_q <= ST_EMIT;
                        end
                    end else begin
                        gap_q <= gap_q + {{(GAP_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_latency_encoder.sv
// Randomized bench for spike_latency_encoder: per-cycle outputs are predicted from the
// firing-time formula (cycle 2 + latency*(1+gap)), the early-stop rule and the reset rule.
module tb_spike_latency_encoder;

    localparam int P_W      = 8;
    localparam int P_S      = 42;
    localparam int P_N      = 8;
    localparam int P_GAP    = 4;
    localparam int TMAX     = (1 << P_W) - 1;
    localparam int LAST_GAP = 2 + TMAX * (P_GAP + 1) + P_GAP;   // final cycle of the window

    logic                 i_clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic                 i_frame_valid = 1'b0;
    logic                 o_frame_ready;
    logic [P_S*P_W-1:0]   i_pixels = '0;
    logic [P_N:1]         i_spike = '0;
    logic [P_S:1]         o_event;
    logic                 o_busy;
    logic                 o_done;
    logic [P_N:1]         o_winner;
    logic                 o_timeout;

    int                   n_cmp = 0;
    int                   n_bad = 0;
    int                   cyc   = 0;
    logic [P_W-1:0]       pix_m [1:P_S];
    logic [P_N:1]         prev_w = '0;
    logic                 prev_t = 1'b0;

    spike_latency_encoder #(
        .p_width (P_W),
        .p_s     (P_S),
        .p_n     (P_N),
        .p_gap   (P_GAP)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_frame_valid (i_frame_valid),
        .o_frame_ready (o_frame_ready),
        .i_pixels      (i_pixels),
        .i_spike       (i_spike),
        .o_event       (o_event),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_winner      (o_winner),
        .o_timeout     (o_timeout)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Reference: which synapses fire in frame-relative cycle c (events stop at stop_at).
    function automatic logic [P_S:1] exp_event(input int c, input int stop_at);
        logic [P_S:1] e;
        int           tick;
        e = '0;
        if (c >= 2 && c < stop_at && ((c - 2) % (P_GAP + 1)) == 0) begin
            tick = (c - 2) / (P_GAP + 1);
            for (int k = 1; k <= P_S; k++) begin
                if (pix_m[k] != 0 && (TMAX - int'(pix_m[k])) == tick) e[k] = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic logic [P_S*P_W-1:0] pack_pixels();
        logic [P_S*P_W-1:0] b;
        b = '0;
        for (int k = 1; k <= P_S; k++) b[k*P_W-1 -: P_W] = pix_m[k];
        return b;
    endfunction

    task automatic clear_pixels();
        for (int k = 1; k <= P_S; k++) pix_m[k] = '0;
    endtask

    task automatic rand_pixels();
        for (int k = 1; k <= P_S; k++) begin
            case ($urandom_range(0, 5))
                0:       pix_m[k] = '0;
                1:       pix_m[k] = P_W'(TMAX);
                default: pix_m[k] = P_W'($urandom_range(0, TMAX));
            endcase
        end
    endtask

    // One frame, accepted in relative cycle 0. spike_at<0: no winner; rst_at>=0: abort there.
    task automatic run_frame(input int spike_at, input logic [P_N:1] spike_val,
                             input int rst_at, input bit hold);
        bit           stop;
        bit           rmode;
        int           done_at;
        int           last_c;
        int           stop_at;
        logic [P_N:1] new_w;
        logic         new_t;
        logic [P_N:1] ew;
        logic         et;
        stop    = (spike_at >= 2 && spike_at <= LAST_GAP && spike_val != '0);
        rmode   = (rst_at >= 0);
        done_at = stop ? spike_at + 1 : LAST_GAP + 1;
        last_c  = rmode ? rst_at + 4 : done_at;
        stop_at = rmode ? rst_at + 1 : done_at;
        new_w   = stop ? spike_val : '0;
        new_t   = ~stop;
        for (int c = 0; c <= last_c; c++) begin
            @(negedge i_clk);
            i_frame_valid = (c == 0) || hold;
            i_pixels      = (c == 0) ? pack_pixels() : {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}[P_S*P_W-1:0];
            i_rst         = rmode && (c == rst_at);
            if (c == spike_at)                          i_spike = spike_val;
            else if (c <= 1 || (!rmode && c == done_at)) i_spike = P_N'($urandom_range(1, 255));
            else                                        i_spike = '0;
            #1;
            if (c == 0) begin
                ew = prev_w; et = prev_t;
            end else if (!rmode && c >= done_at) begin
                ew = new_w;  et = new_t;
            end else begin
                ew = '0;     et = 1'b0;
            end
            chk("event",   64'(o_event), 64'(exp_event(c, stop_at)));
            chk("ready",   64'(o_frame_ready), 64'((c == 0) || (rmode && c > rst_at)));
            chk("busy",    64'(o_busy), 64'(c >= 1 && c < stop_at));
            chk("done",    64'(o_done), 64'(!rmode && c == done_at));
            chk("winner",  64'(o_winner), 64'(ew));
            chk("timeout", 64'(o_timeout), 64'(et));
        end
        i_rst = 1'b0;
        if (rmode) begin
            prev_w = '0; prev_t = 1'b0;
        end else begin
            prev_w = new_w; prev_t = new_t;
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge i_clk);
            i_frame_valid = 1'b0;
            i_spike       = P_N'($urandom);
            #1;
            chk("idle_ready",   64'(o_frame_ready), 64'(1));
            chk("idle_event",   64'(o_event), 64'(0));
            chk("idle_done",    64'(o_done), 64'(0));
            chk("idle_busy",    64'(o_busy), 64'(0));
            chk("idle_winner",  64'(o_winner), 64'(prev_w));
            chk("idle_timeout", 64'(o_timeout), 64'(prev_t));
        end
    endtask

    initial begin
        clear_pixels();
        repeat (3) @(negedge i_clk);
        chk("ready_in_reset", 64'(o_frame_ready), 64'(0));
        i_rst = 1'b0;
        #1;
        chk("rst_ready",   64'(o_frame_ready), 64'(1));
        chk("rst_event",   64'(o_event), 64'(0));
        chk("rst_busy",    64'(o_busy), 64'(0));
        chk("rst_done",    64'(o_done), 64'(0));
        chk("rst_winner",  64'(o_winner), 64'(0));
        chk("rst_timeout", 64'(o_timeout), 64'(0));

        // Brightest single pixel: fires at cycle 2, frame times out at 1282.
        clear_pixels(); pix_m[1] = 8'd255;
        run_frame(-1, '0, -1, 1'b0); idle(2);
        // Two equal pixels fire together.
        clear_pixels(); pix_m[3] = 8'd200; pix_m[7] = 8'd200;
        run_frame(-1, '0, -1, 1'b0); idle(2);
        // Dimmest nonzero fires last; zero never fires.
        clear_pixels(); pix_m[1] = 8'd1; pix_m[2] = 8'd0;
        run_frame(-1, '0, -1, 1'b0); idle(2);
        // Winner spike during a gap cycle ends the frame early.
        rand_pixels();
        run_frame(100, 8'b0000_0100, -1, 1'b0); idle(2);
        // Valid held throughout: ignored mid-frame, next frame accepted straight after DONE.
        rand_pixels();
        run_frame(-1, '0, -1, 1'b1);
        rand_pixels();
        run_frame(600, 8'b0001_0000, -1, 1'b0); idle(2);
        // Reset mid-frame discards the frame.
        rand_pixels();
        run_frame(-1, '0, 50, 1'b0); idle(2);
        // Spike in the final gap cycle: winner wins over timeout, multi-hot kept as-is.
        rand_pixels();
        run_frame(LAST_GAP, 8'b1010_0001, -1, 1'b0); idle(2);
        // Spike on an emit cycle.
        rand_pixels();
        run_frame(2 + 40 * (P_GAP + 1), 8'b0100_0000, -1, 1'b0); idle(1);
        // Random frames.
        for (int i = 0; i < 3; i++) begin
            rand_pixels();
            if ($urandom_range(0, 3) == 0) run_frame(-1, '0, -1, 1'b0);
            else run_frame(int'($urandom_range(2, LAST_GAP)), P_N'($urandom_range(1, 255)), -1, 1'b0);
            idle(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
